// File: rtl/note_sequencer_if.sv
// Load/ROM bundle between note_sequencer, the song ROM and the note_player.
interface note_sequencer_if #(
    parameter int ADDR_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [15:0]           rom_data;
    logic [5:0]            note_to_load;
    logic [1:0]            weight;
    logic                  load_new_note;
    logic                  note_done;
    logic                  play_enable;
    logic                  song_done;

    modport master (
        output rom_addr,
        output note_to_load,
        output weight,
        output load_new_note,
        output note_done,
        output play_enable,
        output song_done,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        input  note_to_load,
        input  weight,
        input  load_new_note,
        input  note_done,
        input  play_enable,
        input  song_done,
        output rom_data
    );
endinterface

// File: rtl/note_sequencer.sv
// Walks the song ROM, issues one note per entry to the player
// and times each note in counted beats.
module note_sequencer #(
    parameter int ADDR_WIDTH = 7,
    parameter int DUR_WIDTH  = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic play,
    input  logic beat,
    note_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_PLAY,
        S_DONE
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = '1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [5:0]            note_q, note_d;
    logic [1:0]            weight_q, weight_d;
    logic [DUR_WIDTH-1:0]  dur_q, dur_d;
    logic [DUR_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  load_q, load_d;
    logic                  done_q, done_d;

    logic                  rom_eos;
    logic [DUR_WIDTH-1:0]  rom_dur;
    logic                  unused_rsvd;

    assign rom_eos     = bus.rom_data[15];
    assign rom_dur     = DUR_WIDTH'(bus.rom_data[8:3]);
    assign unused_rsvd = bus.rom_data[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            note_q   <= '0;
            weight_q <= '0;
            dur_q    <= '0;
            cnt_q    <= '0;
            load_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            note_q   <= note_d;
            weight_q <= weight_d;
            dur_q    <= dur_d;
            cnt_q    <= cnt_d;
            load_q   <= load_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        note_d   = note_q;
        weight_d = weight_q;
        dur_d    = dur_q;
        cnt_d    = cnt_q;
        load_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (play) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (rom_eos) begin
                    state_d = S_DONE;
                end else if (rom_dur == '0) begin
                    if (addr_q == MAX_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    note_d   = bus.rom_data[14:9];
                    weight_d = bus.rom_data[2:1];
                    dur_d    = rom_dur;
                    cnt_d    = '0;
                    load_d   = 1'b1;
                    state_d  = S_PLAY;
                end
            end
            S_PLAY: begin
                // Leave PLAY only after the note_done pulse cycle.
                if (done_q) begin
                    if (addr_q == MAX_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (play && beat) begin
                    if (cnt_q == dur_q - DUR_WIDTH'(1)) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.rom_addr      = addr_q;
    assign bus.note_to_load  = note_q;
    assign bus.weight        = weight_q;
    assign bus.load_new_note = load_q;
    assign bus.note_done     = done_q;
    assign bus.play_enable   = play & (state_q == S_PLAY);
    assign bus.song_done     = (state_q == S_DONE);
endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench: expected note list derived from ROM contents,
// note_done timed by counting play&beat cycles after each load.
module tb_note_sequencer;
    logic clk = 1'b0;
    logic reset, play, beat;

    always #5 clk = ~clk;

    note_sequencer_if #(.ADDR_WIDTH(7)) b0 ();
    note_sequencer_if #(.ADDR_WIDTH(2)) b1 ();

    note_sequencer #(.ADDR_WIDTH(7), .DUR_WIDTH(6)) u0 (
        .clk(clk), .reset(reset), .play(play), .beat(beat), .bus(b0.master)
    );
    note_sequencer #(.ADDR_WIDTH(2), .DUR_WIDTH(6)) u1 (
        .clk(clk), .reset(reset), .play(play), .beat(beat), .bus(b1.master)
    );

    logic [15:0] rom0 [128];
    logic [15:0] rom1 [4];

    always @(posedge clk) begin
        b0.rom_data <= rom0[b0.rom_addr];
        b1.rom_data <= rom1[b1.rom_addr];
    end

    int tests = 0;
    int fails = 0;

    bit       en [2];
    int       nexp [2], rd [2], rem [2], final_addr [2];
    bit       act [2], pend [2];
    logic [5:0] exp_note [2][128];
    logic [1:0] exp_wt [2][128];
    int       exp_dur [2][128];

    function automatic logic [15:0] ent(bit eos, int n, int d, int w);
        logic [15:0] e;
        e = {eos, 6'(n), 6'(d), 2'(w), 1'b0};
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build(int id);
        int mx;
        logic [15:0] e;
        mx = (id == 0) ? 127 : 3;
        nexp[id] = 0; rd[id] = 0; rem[id] = 0;
        act[id] = 0; pend[id] = 0;
        final_addr[id] = mx;
        for (int a = 0; a <= mx; a++) begin
            e = (id == 0) ? rom0[a] : rom1[a % 4];
            if (e[15]) begin
                final_addr[id] = a;
                break;
            end
            if (e[8:3] != 0) begin
                exp_note[id][nexp[id]] = e[14:9];
                exp_wt[id][nexp[id]]   = e[2:1];
                exp_dur[id][nexp[id]]  = int'(e[8:3]);
                nexp[id]++;
            end
        end
    endtask

    task automatic mon(int id, logic ld, logic [5:0] nt, logic [1:0] wt,
                       logic dn, logic pe, logic sd);
        if (!en[id]) return;
        if (ld === 1'b1) begin
            chk($sformatf("d%0d_load_expected", id), rd[id] < nexp[id], 1);
            if (rd[id] < nexp[id]) begin
                chk($sformatf("d%0d_note", id), nt, exp_note[id][rd[id]]);
                chk($sformatf("d%0d_weight", id), wt, exp_wt[id][rd[id]]);
                rem[id] = exp_dur[id][rd[id]];
                rd[id]++;
            end else begin
                rem[id] = 1;
            end
            act[id] = 1; pend[id] = 0;
        end
        chk($sformatf("d%0d_note_done", id), dn, pend[id]);
        if (act[id] && !pend[id])
            chk($sformatf("d%0d_play_enable", id), pe, play);
        else if (!act[id])
            chk($sformatf("d%0d_play_enable_off", id), pe, 0);
        if (sd === 1'b1)
            chk($sformatf("d%0d_song_done_early", id),
                (rd[id] < nexp[id]) || act[id], 0);
        if (pend[id]) begin
            pend[id] = 0; act[id] = 0;
        end else if (act[id] && play && beat) begin
            rem[id]--;
            if (rem[id] == 0) pend[id] = 1;
        end
    endtask

    always @(negedge clk) begin
        mon(0, b0.load_new_note, b0.note_to_load, b0.weight,
            b0.note_done, b0.play_enable, b0.song_done);
        mon(1, b1.load_new_note, b1.note_to_load, b1.weight,
            b1.note_done, b1.play_enable, b1.song_done);
    end

    task automatic gen_rom0(int len, bit allow_skip);
        for (int a = 0; a < 128; a++) rom0[a] = ent(1, 0, 0, 0);
        for (int a = 0; a < len; a++)
            rom0[a] = ent(0, $urandom_range(0, 63),
                          (allow_skip && $urandom_range(0, 3) == 0)
                              ? 0 : $urandom_range(1, 5),
                          $urandom_range(0, 3));
    endtask

    task automatic gen_rom1(bit allow_skip);
        for (int a = 0; a < 4; a++)
            rom1[a] = ent(0, $urandom_range(0, 63),
                          (allow_skip && $urandom_range(0, 2) == 0)
                              ? 0 : $urandom_range(1, 4),
                          $urandom_range(0, 3));
    endtask

    task automatic reset_dut();
        en[0] = 0; en[1] = 0;
        reset = 1; play = 0; beat = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rom_addr", b0.rom_addr, 0);
        chk("rst_note", b0.note_to_load, 0);
        chk("rst_weight", b0.weight, 0);
        chk("rst_pulses", {b0.load_new_note, b0.note_done}, 0);
        chk("rst_song_done", {b0.song_done, b1.song_done}, 0);
        chk("rst_addr1", b1.rom_addr, 0);
    endtask

    // mode 0: steady play, beat every 4 cycles
    // mode 1: random play/beat
    // mode 2: steady beats with a long pause spanning ten beats
    task automatic run_song(int mode);
        bit ok;
        reset_dut();
        build(0); build(1);
        reset = 0; en[0] = 1; en[1] = 1;
        ok = 0;
        for (int c = 0; c < 4000; c++) begin
            if (mode == 1) begin
                play = ($urandom_range(0, 3) != 0);
                beat = ($urandom_range(0, 2) == 0);
            end else begin
                play = !(mode == 2 && c >= 5 && c < 45);
                beat = (c % 4 == 3);
            end
            @(posedge clk); #1;
            if (b0.song_done && b1.song_done) begin
                ok = 1;
                break;
            end
        end
        chk("song_finished", ok, 1);
        for (int c = 0; c < 6; c++) begin
            play = $urandom_range(0, 1);
            beat = $urandom_range(0, 1);
            @(posedge clk); #1;
        end
        chk("final_addr0", b0.rom_addr, final_addr[0]);
        chk("final_addr1", b1.rom_addr, final_addr[1]);
        chk("all_loaded0", rd[0], nexp[0]);
        chk("all_loaded1", rd[1], nexp[1]);
        chk("done_sticky", {b0.song_done, b1.song_done}, 2'b11);
        chk("done_pe_off", {b0.play_enable, b1.play_enable}, 0);
    endtask

    task automatic reset_mid_play();
        bit seen;
        gen_rom0(5, 0);
        rom0[0] = ent(0, 9, 0, 1);
        rom0[1] = ent(0, 37, 5, 3);
        gen_rom1(0);
        reset_dut();
        build(0); build(1);
        reset = 0; en[0] = 1; en[1] = 1;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            play = 1; beat = 0;
            @(posedge clk); #1;
            if (b0.load_new_note) begin
                seen = 1;
                break;
            end
        end
        chk("mid_load_seen", seen, 1);
        chk("mid_addr_moved", b0.rom_addr, 1);
        play = 1; beat = 1;
        repeat (2) @(posedge clk);
        #1;
        en[0] = 0; en[1] = 0;
        reset = 1;
        @(posedge clk); #1;
        chk("mid_rst_addr", b0.rom_addr, 0);
        chk("mid_rst_note", b0.note_to_load, 0);
        chk("mid_rst_weight", b0.weight, 0);
        chk("mid_rst_pulses", {b0.load_new_note, b0.note_done}, 0);
        chk("mid_rst_pe", b0.play_enable, 0);
        chk("mid_rst_sd", b0.song_done, 0);
        reset = 0; play = 0; beat = 1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("idle_hold", {b0.rom_addr, b0.load_new_note, b0.play_enable}, 0);
        end
    endtask

    initial begin
        reset = 1; play = 0; beat = 0;
        for (int a = 0; a < 128; a++) rom0[a] = ent(1, 0, 0, 0);
        for (int a = 0; a < 4; a++) rom1[a] = ent(0, 0, 1, 0);

        rom0[0] = ent(0, 20, 3, 2);
        rom0[1] = ent(1, 0, 0, 0);
        gen_rom1(0);
        run_song(0);

        gen_rom1(0);
        run_song(2);

        for (int k = 0; k < 6; k++) begin
            gen_rom0($urandom_range(2, 8), 1);
            gen_rom1(k > 2);
            run_song(1);
        end

        reset_mid_play();

        gen_rom0(4, 1);
        gen_rom1(1);
        run_song(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
